// File: rtl/bin_to_gray.sv
// Binary-to-Gray encoder with Gray-to-binary decoder.
// Optional registered Gray copy with valid flag for CDC launch.
module bin_to_gray #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o,
    input  logic             en_i,
    output logic [WIDTH-1:0] gray_q_o,
    output logic             valid_o,
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    logic [WIDTH-1:0] gray_reg_d;
    logic [WIDTH-1:0] gray_reg_q;
    logic             valid_d;
    logic             valid_q;
    logic [WIDTH-1:0] bin_dec;

    // Zero-latency encode: each bit depends only on its own and next-higher input bit
    assign gray_o = bin_i ^ (bin_i >> 1);

    // Decode as a running XOR from the MSB downwards
    always_comb begin
        bin_dec            = '0;
        bin_dec[WIDTH-1]   = gray_i[WIDTH-1];
        for (int k = WIDTH - 2; k >= 0; k--) begin
            bin_dec[k] = bin_dec[k+1] ^ gray_i[k];
        end
    end

    assign bin_o = bin_dec;

    // Next state of the launch register: capture on enable, otherwise hold
    always_comb begin
        gray_reg_d = gray_reg_q;
        valid_d    = 1'b0;
        if (en_i) begin
            gray_reg_d = gray_o;
            valid_d    = 1'b1;
        end
    end

    // Launch flops; reset wins over enable
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gray_reg_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            gray_reg_q <= gray_reg_d;
            valid_q    <= valid_d;
        end
    end

    // Outputs come straight from flops so the CDC path sees no glitches
    assign gray_q_o = gray_reg_q;
    assign valid_o  = valid_q;

endmodule

// File: tb/tb_bin_to_gray.sv
// Self-checking bench for bin_to_gray (WIDTH=8).
// Reference Gray table is built by reflect-and-prefix construction.
module tb_bin_to_gray;

    logic       clk;
    logic       run_clk;
    logic       rst;
    logic [7:0] bin;
    logic [7:0] gray;
    logic       en;
    logic [7:0] gray_q;
    logic       valid;
    logic [7:0] gray_in;
    logic [7:0] bin_out;

    int checks;
    int errors;

    logic [7:0] codes [256];
    logic [7:0] inv   [256];

    bin_to_gray #(.WIDTH(8)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .bin_i   (bin),
        .gray_o  (gray),
        .en_i    (en),
        .gray_q_o(gray_q),
        .valid_o (valid),
        .gray_i  (gray_in),
        .bin_o   (bin_out)
    );

    // Clock only toggles once the registered-path section starts
    always begin
        #5;
        if (run_clk) clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int         n;
        logic [7:0] spot_in  [6];
        logic [7:0] spot_out [6];
        logic [7:0] exp_q;
        logic       exp_v;
        logic [7:0] r;

        checks  = 0;
        errors  = 0;
        clk     = 1'b0;
        run_clk = 1'b0;
        rst     = 1'b0;
        en      = 1'b0;
        bin     = 8'h00;
        gray_in = 8'h00;

        // Reflected Gray code: mirror the list, set the new top bit
        codes[0] = 8'h00;
        n = 1;
        for (int b = 0; b < 8; b++) begin
            for (int j = 0; j < n; j++) begin
                codes[2*n-1-j] = codes[j] | (8'(1) << b);
            end
            n = n * 2;
        end
        for (int i = 0; i < 256; i++) inv[codes[i]] = 8'(i);

        // Exhaustive sweep with no clock and no reset
        for (int i = 0; i < 256; i++) begin
            bin = 8'(i);
            #1;
            check("sweep", gray, codes[i]);
        end

        spot_in  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h80, 8'hFF};
        spot_out = '{8'h00, 8'h01, 8'h03, 8'h02, 8'hC0, 8'h80};
        for (int i = 0; i < 6; i++) begin
            bin = spot_in[i];
            #1;
            check("spot", gray, spot_out[i]);
        end

        // Single-bit change between neighbours, including the wrap
        for (int i = 0; i < 256; i++) begin
            bin = 8'(i);
            #1;
            r = gray;
            bin = 8'((i + 1) % 256);
            #1;
            check("adjacent", 8'($countones(r ^ gray)), 8'd1);
        end

        // Round trip with decoder fed from encoder
        for (int i = 0; i < 256; i++) begin
            bin = 8'(i);
            #1;
            gray_in = gray;
            #1;
            check("roundtrip", bin_out, 8'(i));
        end
        gray_in = 8'h80;
        #1;
        check("dec_80", bin_out, 8'hFF);

        // Random decode against inverse table
        for (int i = 0; i < 64; i++) begin
            gray_in = 8'($urandom_range(0, 255));
            #1;
            check("dec_rand", bin_out, inv[gray_in]);
        end

        // Registered path
        run_clk = 1'b1;
        rst = 1'b1;
        en  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_q", gray_q, 8'h00);
        check("rst_v", {7'd0, valid}, 8'd0);

        rst = 1'b0;
        en  = 1'b1;
        bin = 8'h05;
        @(posedge clk);
        #1;
        check("cap_q", gray_q, 8'h07);
        check("cap_v", {7'd0, valid}, 8'd1);

        en  = 1'b0;
        bin = 8'hFF;
        @(posedge clk);
        #1;
        check("hold_q", gray_q, 8'h07);
        check("hold_v", {7'd0, valid}, 8'd0);

        rst = 1'b1;
        en  = 1'b1;
        #1;
        check("comb_in_rst", gray, 8'h80);
        @(posedge clk);
        #1;
        check("midrst_q", gray_q, 8'h00);
        check("midrst_v", {7'd0, valid}, 8'd0);

        // Random registered traffic with occasional reset
        exp_q = 8'h00;
        exp_v = 1'b0;
        for (int i = 0; i < 200; i++) begin
            rst = ($urandom_range(0, 7) == 0);
            en  = 1'($urandom_range(0, 1));
            bin = 8'($urandom_range(0, 255));
            @(posedge clk);
            if (rst) begin
                exp_q = 8'h00;
                exp_v = 1'b0;
            end else if (en) begin
                exp_q = codes[bin];
                exp_v = 1'b1;
            end else begin
                exp_v = 1'b0;
            end
            #1;
            check("rand_q", gray_q, exp_q);
            check("rand_v", {7'd0, valid}, {7'd0, exp_v});
            check("rand_comb", gray, codes[bin]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
